// File: rtl/axi_arbiter_n.sv
// N-channel AXI4 master arbiter, read/write granted independently per burst; ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
// Latency: request seen in IDLE gives downstream valid next cycle; payloads muxed combinationally.
// Backpressure: ready/valid pass straight through to the granted channel only; all others see ready=0, valid=0.
module axi_arbiter_n #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NCH-1:0]           in_arvalid,
  output logic [NCH-1:0]           in_arready,
  input  logic [NCH*ADDR_W-1:0]    in_araddr,
  input  logic [NCH*8-1:0]         in_arlen,
  input  logic [NCH*3-1:0]         in_arsize,
  output logic [NCH-1:0]           in_rvalid,
  input  logic [NCH-1:0]           in_rready,
  output logic [DATA_W-1:0]        in_rdata,
  output logic [1:0]               in_rresp,
  output logic                     in_rlast,
  input  logic [NCH-1:0]           in_awvalid,
  output logic [NCH-1:0]           in_awready,
  input  logic [NCH*ADDR_W-1:0]    in_awaddr,
  input  logic [NCH*8-1:0]         in_awlen,
  input  logic [NCH*3-1:0]         in_awsize,
  input  logic [NCH-1:0]           in_wvalid,
  output logic [NCH-1:0]           in_wready,
  input  logic [NCH*DATA_W-1:0]    in_wdata,
  input  logic [NCH*DATA_W/8-1:0]  in_wstrb,
  input  logic [NCH-1:0]           in_wlast,
  output logic [NCH-1:0]           in_bvalid,
  input  logic [NCH-1:0]           in_bready,
  output logic [1:0]               in_bresp,
  input  logic                     io_master_awready,
  output logic                     io_master_awvalid,
  output logic [ADDR_W-1:0]        io_master_awaddr,
  output logic [ID_W-1:0]          io_master_awid,
  output logic [7:0]               io_master_awlen,
  output logic [2:0]               io_master_awsize,
  output logic [1:0]               io_master_awburst,
  input  logic                     io_master_wready,
  output logic                     io_master_wvalid,
  output logic [DATA_W-1:0]        io_master_wdata,
  output logic [DATA_W/8-1:0]      io_master_wstrb,
  output logic                     io_master_wlast,
  output logic                     io_master_bready,
  input  logic                     io_master_bvalid,
  input  logic [1:0]               io_master_bresp,
  input  logic [ID_W-1:0]          io_master_bid,
  input  logic                     io_master_arready,
  output logic                     io_master_arvalid,
  output logic [ADDR_W-1:0]        io_master_araddr,
  output logic [ID_W-1:0]          io_master_arid,
  output logic [7:0]               io_master_arlen,
  output logic [2:0]               io_master_arsize,
  output logic [1:0]               io_master_arburst,
  output logic                     io_master_rready,
  input  logic                     io_master_rvalid,
  input  logic [1:0]               io_master_rresp,
  input  logic [DATA_W-1:0]        io_master_rdata,
  input  logic                     io_master_rlast,
  input  logic [ID_W-1:0]          io_master_rid
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;

  r_state_t      r_state;
  w_state_t      w_state;
  logic [GW-1:0] rgnt, wgnt;
  logic          aw_done, w_done;
  logic [GW:0]   ar_pick, aw_pick;
  logic          aw_hs, w_last_hs;
  logic          unused_ids;

  // Result is {found, index}.
`ifdef ARB_ROUND_ROBIN_EN
  function automatic logic [GW:0] pick(input logic [NCH-1:0] req, input logic [GW-1:0] last);
    logic [GW:0] res;
    int idx;
    res = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(last) + 1 + k) % NCH;
      if (!res[GW] && req[idx]) res = {1'b1, GW'(idx)};
    end
    return res;
  endfunction

  logic [GW-1:0] r_ptr, w_ptr;
  assign ar_pick = pick(in_arvalid, r_ptr);
  assign aw_pick = pick(in_awvalid, w_ptr);
`else
  function automatic logic [GW:0] pick(input logic [NCH-1:0] req);
    logic [GW:0] res;
    res = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (req[k]) res = {1'b1, GW'(k)};
    return res;
  endfunction

  assign ar_pick = pick(in_arvalid);
  assign aw_pick = pick(in_awvalid);
`endif

  assign aw_hs     = io_master_awvalid && io_master_awready;
  assign w_last_hs = io_master_wvalid && io_master_wready && io_master_wlast;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= R_IDLE;
      rgnt              <= '0;
      io_master_arvalid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr             <= GW'(NCH - 1);
`endif
    end else begin
      case (r_state)
        R_IDLE: if (ar_pick[GW]) begin
          rgnt              <= ar_pick[GW-1:0];
          io_master_arvalid <= 1'b1;
          r_state           <= R_AR;
`ifdef ARB_ROUND_ROBIN_EN
          r_ptr             <= ar_pick[GW-1:0];
`endif
        end
        R_AR: if (io_master_arready) begin
          io_master_arvalid <= 1'b0;
          r_state           <= R_DATA;
        end
        R_DATA: if (io_master_rvalid && io_master_rready && io_master_rlast) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // AW and W are forwarded together so slaves that wait for both cannot deadlock.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state           <= W_IDLE;
      wgnt              <= '0;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      io_master_awvalid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      w_ptr             <= GW'(NCH - 1);
`endif
    end else begin
      case (w_state)
        W_IDLE: if (aw_pick[GW]) begin
          wgnt              <= aw_pick[GW-1:0];
          aw_done           <= 1'b0;
          w_done            <= 1'b0;
          io_master_awvalid <= 1'b1;
          w_state           <= W_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          w_ptr             <= aw_pick[GW-1:0];
`endif
        end
        W_ADDR: begin
          if (aw_hs) begin
            aw_done           <= 1'b1;
            io_master_awvalid <= 1'b0;
          end
          if (w_last_hs) w_done <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_last_hs)) w_state <= W_RESP;
        end
        W_RESP: if (io_master_bvalid && io_master_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    in_arready       = '0;
    in_rvalid        = '0;
    io_master_rready = 1'b0;
    in_awready       = '0;
    in_wready        = '0;
    in_bvalid        = '0;
    io_master_wvalid = 1'b0;
    io_master_bready = 1'b0;
    if (r_state == R_AR) in_arready[rgnt] = io_master_arready;
    if (r_state == R_DATA) begin
      io_master_rready = in_rready[rgnt];
      in_rvalid[rgnt]  = io_master_rvalid;
    end
    if (io_master_awvalid) in_awready[wgnt] = io_master_awready;
    if (w_state == W_ADDR && !w_done) begin
      io_master_wvalid = in_wvalid[wgnt];
      in_wready[wgnt]  = io_master_wready;
    end
    if (w_state == W_RESP) begin
      io_master_bready = in_bready[wgnt];
      in_bvalid[wgnt]  = io_master_bvalid;
    end
  end

  assign io_master_araddr  = in_araddr[rgnt*ADDR_W +: ADDR_W];
  assign io_master_arlen   = in_arlen[rgnt*8 +: 8];
  assign io_master_arsize  = in_arsize[rgnt*3 +: 3];
  assign io_master_arid    = ID_W'(rgnt);
  assign io_master_arburst = 2'b01;
  assign io_master_awaddr  = in_awaddr[wgnt*ADDR_W +: ADDR_W];
  assign io_master_awlen   = in_awlen[wgnt*8 +: 8];
  assign io_master_awsize  = in_awsize[wgnt*3 +: 3];
  assign io_master_awid    = ID_W'(wgnt);
  assign io_master_awburst = 2'b01;
  assign io_master_wdata   = in_wdata[wgnt*DATA_W +: DATA_W];
  assign io_master_wstrb   = in_wstrb[wgnt*SW +: SW];
  assign io_master_wlast   = in_wlast[wgnt];

  assign in_rdata = io_master_rdata;
  assign in_rresp = io_master_rresp;
  assign in_rlast = io_master_rlast;
  assign in_bresp = io_master_bresp;

  // Responses are routed by ownership, so returned IDs carry no information here.
  assign unused_ids = ^{io_master_rid, io_master_bid};
endmodule

// File: tb/tb_axi_arbiter_n.sv
// Directed bench for axi_arbiter_n with NCH=2; expected arbitration order follows ARB_ROUND_ROBIN_EN.
module tb_axi_arbiter_n;
  logic clock = 1'b0;
  logic reset;
  logic [1:0]  in_arvalid, in_arready, in_rvalid, in_rready;
  logic [63:0] in_araddr;
  logic [15:0] in_arlen;
  logic [5:0]  in_arsize;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic        in_rlast;
  logic [1:0]  in_awvalid, in_awready, in_wvalid, in_wready, in_wlast, in_bvalid, in_bready;
  logic [63:0] in_awaddr, in_wdata;
  logic [15:0] in_awlen;
  logic [5:0]  in_awsize;
  logic [7:0]  in_wstrb;
  logic [1:0]  in_bresp;
  logic        io_master_awready, io_master_awvalid, io_master_wready, io_master_wvalid, io_master_wlast;
  logic [31:0] io_master_awaddr, io_master_wdata, io_master_araddr, io_master_rdata;
  logic [3:0]  io_master_awid, io_master_wstrb, io_master_bid, io_master_arid, io_master_rid;
  logic [7:0]  io_master_awlen, io_master_arlen;
  logic [2:0]  io_master_awsize, io_master_arsize;
  logic [1:0]  io_master_awburst, io_master_arburst, io_master_bresp, io_master_rresp;
  logic        io_master_bready, io_master_bvalid, io_master_arready, io_master_arvalid;
  logic        io_master_rready, io_master_rvalid, io_master_rlast;
  int passed = 0;
  int total  = 0;

  axi_arbiter_n #(.NCH(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .in_arvalid(in_arvalid), .in_arready(in_arready), .in_araddr(in_araddr), .in_arlen(in_arlen),
    .in_arsize(in_arsize), .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata),
    .in_rresp(in_rresp), .in_rlast(in_rlast),
    .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awaddr(in_awaddr), .in_awlen(in_awlen),
    .in_awsize(in_awsize), .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata),
    .in_wstrb(in_wstrb), .in_wlast(in_wlast), .in_bvalid(in_bvalid), .in_bready(in_bready),
    .in_bresp(in_bresp),
    .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst), .io_master_wready(io_master_wready),
    .io_master_wvalid(io_master_wvalid), .io_master_wdata(io_master_wdata),
    .io_master_wstrb(io_master_wstrb), .io_master_wlast(io_master_wlast),
    .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst), .io_master_rready(io_master_rready),
    .io_master_rvalid(io_master_rvalid), .io_master_rresp(io_master_rresp),
    .io_master_rdata(io_master_rdata), .io_master_rlast(io_master_rlast),
    .io_master_rid(io_master_rid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    in_arvalid = '0; in_araddr = '0; in_arlen = '0; in_arsize = '0; in_rready = '0;
    in_awvalid = '0; in_awaddr = '0; in_awlen = '0; in_awsize = '0;
    in_wvalid = '0; in_wdata = '0; in_wstrb = '0; in_wlast = '0; in_bready = '0;
    io_master_awready = 0; io_master_wready = 0; io_master_bvalid = 0; io_master_bresp = '0;
    io_master_bid = '0; io_master_arready = 0; io_master_rvalid = 0; io_master_rresp = '0;
    io_master_rdata = '0; io_master_rlast = 0; io_master_rid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    in_arvalid = 2'b11; in_awvalid = 2'b11;
    tick(); tick();
    total++; if ({io_master_arvalid, io_master_awvalid, io_master_wvalid, io_master_rready, io_master_bready,
                  in_arready, in_awready, in_wready, in_rvalid, in_bvalid} !== 15'd0)
      $display("FAIL reset_valids got=%b exp=0", {io_master_arvalid, io_master_awvalid, io_master_wvalid,
               io_master_rready, io_master_bready, in_arready, in_awready, in_wready, in_rvalid, in_bvalid});
    else passed++;
    total++; if ({io_master_arburst, io_master_awburst} !== 4'b0101)
      $display("FAIL reset_burst got=%b exp=0101", {io_master_arburst, io_master_awburst});
    else passed++;
    in_arvalid = '0; in_awvalid = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_burst();
    in_arvalid = 2'b10; in_araddr[32 +: 32] = 32'h8000_0000; in_arlen[8 +: 8] = 8'd3; in_arsize[3 +: 3] = 3'd2;
    #1;
    total++; if (io_master_arvalid !== 1'b0) $display("FAIL rd_latency arvalid=%b exp=0", io_master_arvalid); else passed++;
    tick();
    total++; if ({io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen, io_master_arsize} !==
                 {1'b1, 32'h8000_0000, 4'd1, 8'd3, 3'd2})
      $display("FAIL rd_ar got=%h exp=%h", {io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
               io_master_arsize}, {1'b1, 32'h8000_0000, 4'd1, 8'd3, 3'd2});
    else passed++;
    total++; if (in_arready !== 2'b00) $display("FAIL rd_arready_wait got=%b exp=00", in_arready); else passed++;
    io_master_arready = 1; #1;
    total++; if (in_arready !== 2'b10) $display("FAIL rd_arready got=%b exp=10", in_arready); else passed++;
    tick();
    in_arvalid = '0; io_master_arready = 0; in_rready = 2'b10; #1;
    total++; if (io_master_arvalid !== 1'b0) $display("FAIL rd_ar_drop arvalid=%b exp=0", io_master_arvalid); else passed++;
    for (int b = 0; b < 4; b++) begin
      io_master_rvalid = 1; io_master_rdata = 32'h100 + b; io_master_rlast = (b == 3); #1;
      total++; if ({in_rvalid, io_master_rready, in_rdata, in_rlast} !== {2'b10, 1'b1, 32'h100 + b, b == 3})
        $display("FAIL rd_beat%0d got=%h exp=%h", b, {in_rvalid, io_master_rready, in_rdata, in_rlast},
                 {2'b10, 1'b1, 32'h100 + b, b == 3});
      else passed++;
      tick();
    end
    #1;
    total++; if ({in_rvalid, io_master_rready} !== 3'b000)
      $display("FAIL rd_idle got=%b exp=000", {in_rvalid, io_master_rready});
    else passed++;
    clear_inputs();
  endtask

  task automatic test_arbitration();
    int g;
    in_arvalid = 2'b11; in_rready = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      g = i % 2;
`else
      g = 0;
`endif
      tick();
      total++; if ({io_master_arvalid, io_master_arid} !== {1'b1, 4'(g)})
        $display("FAIL arb_grant%0d got=%h exp=%h", i, {io_master_arvalid, io_master_arid}, {1'b1, 4'(g)});
      else passed++;
      io_master_arready = 1; #1;
      total++; if (in_arready !== (2'b01 << g))
        $display("FAIL arb_arready%0d got=%b exp=%b", i, in_arready, 2'b01 << g);
      else passed++;
      tick();
      io_master_arready = 0; io_master_rvalid = 1; io_master_rlast = 1; #1;
      total++; if (in_rvalid !== (2'b01 << g))
        $display("FAIL arb_rvalid%0d got=%b exp=%b", i, in_rvalid, 2'b01 << g);
      else passed++;
      tick();
      io_master_rvalid = 0; io_master_rlast = 0;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_concurrent();
    in_awvalid = 2'b01; in_awaddr[0 +: 32] = 32'h8000_0010; in_awsize[0 +: 3] = 3'd2;
    in_wvalid = 2'b01; in_wdata[0 +: 32] = 32'hdead_beef; in_wstrb[0 +: 4] = 4'hf; in_wlast = 2'b01;
    in_bready = 2'b11; in_rready = 2'b11;
    in_arvalid = 2'b10; in_araddr[32 +: 32] = 32'h8000_0020;
    io_master_awready = 1; io_master_wready = 1; io_master_arready = 1;
    tick();
    total++; if ({io_master_awvalid, io_master_wvalid, io_master_arvalid, in_awready, in_wready, in_arready} !== 9'b111_01_01_10)
      $display("FAIL cc_handshake got=%b exp=111010110", {io_master_awvalid, io_master_wvalid, io_master_arvalid,
               in_awready, in_wready, in_arready});
    else passed++;
    total++; if ({io_master_awaddr, io_master_awid, io_master_wdata, io_master_wstrb, io_master_wlast} !==
                 {32'h8000_0010, 4'd0, 32'hdead_beef, 4'hf, 1'b1})
      $display("FAIL cc_wpayload got=%h exp=%h", {io_master_awaddr, io_master_awid, io_master_wdata, io_master_wstrb,
               io_master_wlast}, {32'h8000_0010, 4'd0, 32'hdead_beef, 4'hf, 1'b1});
    else passed++;
    total++; if ({io_master_araddr, io_master_arid} !== {32'h8000_0020, 4'd1})
      $display("FAIL cc_ar got=%h exp=%h", {io_master_araddr, io_master_arid}, {32'h8000_0020, 4'd1});
    else passed++;
    tick();
    in_awvalid = '0; in_wvalid = '0; in_wlast = '0; in_arvalid = '0;
    io_master_awready = 0; io_master_wready = 0; io_master_arready = 0;
    io_master_bvalid = 1; io_master_bid = 4'h1; io_master_rvalid = 1; io_master_rlast = 1;
    io_master_rdata = 32'h5555_aaaa; io_master_rid = 4'h0; #1;
    total++; if ({in_bvalid, in_rvalid, io_master_bready, io_master_rready, io_master_awvalid, io_master_wvalid} !== 8'b01_10_1100)
      $display("FAIL cc_resp got=%b exp=01101100", {in_bvalid, in_rvalid, io_master_bready, io_master_rready,
               io_master_awvalid, io_master_wvalid});
    else passed++;
    total++; if (in_rdata !== 32'h5555_aaaa) $display("FAIL cc_rdata got=%h exp=5555aaaa", in_rdata); else passed++;
    tick();
    #1;
    total++; if ({in_bvalid, in_rvalid} !== 4'b0000)
      $display("FAIL cc_idle got=%b exp=0000", {in_bvalid, in_rvalid});
    else passed++;
    clear_inputs();
  endtask

  task automatic test_aw_after_w();
    in_awvalid = 2'b01; in_awaddr[0 +: 32] = 32'h8000_0030; in_wvalid = 2'b01; in_wlast = 2'b01;
    in_wdata[0 +: 32] = 32'h1234_5678; in_wstrb[0 +: 4] = 4'h3; in_bready = 2'b01;
    io_master_wready = 1;
    tick();
    total++; if ({io_master_awvalid, io_master_wvalid, in_awready, in_wready} !== 6'b11_00_01)
      $display("FAIL aw_w_first got=%b exp=110001", {io_master_awvalid, io_master_wvalid, in_awready, in_wready});
    else passed++;
    tick();
    in_wvalid = '0; in_wlast = '0; io_master_wready = 0; #1;
    total++; if ({io_master_awvalid, io_master_wvalid} !== 2'b10)
      $display("FAIL aw_hold got=%b exp=10", {io_master_awvalid, io_master_wvalid});
    else passed++;
    io_master_awready = 1; #1;
    total++; if (in_awready !== 2'b01) $display("FAIL aw_late_ready got=%b exp=01", in_awready); else passed++;
    tick();
    in_awvalid = '0; io_master_awready = 0; io_master_bvalid = 1; io_master_bresp = 2'b10; #1;
    total++; if ({in_bvalid, in_bresp, io_master_bready, io_master_awvalid} !== 6'b01_10_10)
      $display("FAIL aw_bresp got=%b exp=011010", {in_bvalid, in_bresp, io_master_bready, io_master_awvalid});
    else passed++;
    tick();
    clear_inputs();
  endtask

  task automatic test_rresp_err();
    logic [1:0] er;
    in_arvalid = 2'b01; in_araddr[0 +: 32] = 32'h8000_0040; in_arlen[0 +: 8] = 8'd3; in_rready = 2'b01;
    tick();
    total++; if ({io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen} !== {1'b1, 32'h8000_0040, 4'd0, 8'd3})
      $display("FAIL re_ar got=%h exp=%h", {io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen},
               {1'b1, 32'h8000_0040, 4'd0, 8'd3});
    else passed++;
    io_master_arready = 1;
    tick();
    in_arvalid = '0; io_master_arready = 0;
    for (int b = 0; b < 4; b++) begin
      er = (b == 1) ? 2'b10 : 2'b00;
      io_master_rvalid = 1; io_master_rresp = er; io_master_rlast = (b == 3); #1;
      total++; if ({in_rvalid, in_rresp} !== {2'b01, er})
        $display("FAIL re_beat%0d got=%b exp=%b", b, {in_rvalid, in_rresp}, {2'b01, er});
      else passed++;
      tick();
    end
    #1;
    total++; if (in_rvalid !== 2'b00) $display("FAIL re_done got=%b exp=00", in_rvalid); else passed++;
    clear_inputs();
  endtask

  task automatic test_withdraw();
    in_arvalid = 2'b10; #1;
    in_arvalid = 2'b00;
    tick();
    total++; if (io_master_arvalid !== 1'b0) $display("FAIL wd_nogrant arvalid=%b exp=0", io_master_arvalid); else passed++;
    tick();
    total++; if (io_master_arvalid !== 1'b0) $display("FAIL wd_still arvalid=%b exp=0", io_master_arvalid); else passed++;
  endtask

  task automatic test_reset_mid();
    in_arvalid = 2'b01; in_araddr[0 +: 32] = 32'h8000_0050; in_arlen[0 +: 8] = 8'd3; in_rready = 2'b01;
    tick();
    io_master_arready = 1;
    tick();
    in_arvalid = '0; io_master_arready = 0; io_master_rvalid = 1; #1;
    total++; if (in_rvalid !== 2'b01) $display("FAIL rm_beat1 got=%b exp=01", in_rvalid); else passed++;
    tick();
    reset = 1; io_master_rvalid = 0;
    tick();
    reset = 0; #1;
    total++; if ({io_master_arvalid, io_master_awvalid, io_master_wvalid, in_rvalid, in_bvalid, io_master_rready} !== 8'd0)
      $display("FAIL rm_valids got=%b exp=0", {io_master_arvalid, io_master_awvalid, io_master_wvalid, in_rvalid,
               in_bvalid, io_master_rready});
    else passed++;
    io_master_rvalid = 1; #1;
    total++; if ({in_rvalid, io_master_rready} !== 3'b000)
      $display("FAIL rm_idle got=%b exp=000", {in_rvalid, io_master_rready});
    else passed++;
    io_master_rvalid = 0; in_arvalid = 2'b01;
    tick();
    total++; if ({io_master_arvalid, io_master_arid, io_master_araddr} !== {1'b1, 4'd0, 32'h8000_0050})
      $display("FAIL rm_regrant got=%h exp=%h", {io_master_arvalid, io_master_arid, io_master_araddr},
               {1'b1, 4'd0, 32'h8000_0050});
    else passed++;
    io_master_arready = 1;
    tick();
    in_arvalid = '0; io_master_arready = 0; io_master_rvalid = 1; io_master_rlast = 1; #1;
    total++; if (in_rvalid !== 2'b01) $display("FAIL rm_rdata got=%b exp=01", in_rvalid); else passed++;
    tick();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_burst();
    test_arbitration();
    test_concurrent();
    test_aw_after_w();
    test_rresp_err();
    test_withdraw();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
